// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory slice.
// Imported by the bus interface, the storage array and the top.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LAT_CNT_W = 4;

   // Number of byte lanes in a word of the given width.
   function automatic int BYTES(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/dmem_waitstate_if.sv
// Request/response bus between the memory stage (master) and the wait-state memory (slave).
interface dmem_waitstate_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);

   logic                                 req_valid;
   logic                                 req_ready;
   logic                                 req_we;
   logic [ADDR_W-1:0]                    req_addr;
   logic [DATA_W-1:0]                    req_wdata;
   logic [dmem_pkg::BYTES(DATA_W)-1:0]   req_be;
   logic                                 resp_valid;
   logic [DATA_W-1:0]                    resp_rdata;
   logic                                 resp_err;

   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_wdata,
      output req_be,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_wdata,
      input  req_be,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_err
   );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with byte-lane synchronous write and synchronous read.
// Contents are never initialised or cleared; the caller keeps out-of-range addresses away via en.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic                       clk,
   input  logic                       en,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [BYTES(DATA_W)-1:0]   be,
   output logic [DATA_W-1:0]          rdata
);

   localparam int BE_W  = BYTES(DATA_W);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;

   assign idx = addr[IDX_W-1:0];

   // A write touches only enabled lanes and leaves rdata alone; a read loads the whole word.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) begin
                  mem[idx][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_waitstate.sv
// Data memory with configurable wait states, valid/ready request handshake,
// one-cycle response pulse and out-of-range error reporting.
module dmem_waitstate
   import dmem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   dmem_waitstate_if.slave  bus
);

   localparam int                     BE_W     = BYTES(DATA_W);
   localparam logic [LAT_CNT_W-1:0]   LOAD_VAL = LAT_CNT_W'(LATENCY - 1);
   localparam logic [LAT_CNT_W-1:0]   CNT_ONE  = LAT_CNT_W'(1);
   localparam logic [ADDR_W:0]        DEPTH_L  = (ADDR_W + 1)'(DEPTH);

   state_t                state_q;
   state_t                state_d;
   logic [LAT_CNT_W-1:0]  cnt_q;
   logic [LAT_CNT_W-1:0]  cnt_d;
   logic                  accept;
   logic                  access;

   logic                  we_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [BE_W-1:0]       be_q;

   logic                  acc_we;
   logic [ADDR_W-1:0]     acc_addr;
   logic [DATA_W-1:0]     acc_wdata;
   logic [BE_W-1:0]       acc_be;
   logic                  in_range;
   logic                  arr_en;
   logic [DATA_W-1:0]     arr_rdata;

   logic                  resp_valid_q;
   logic                  rd_sel_q;
   logic                  resp_err_q;

   assign bus.req_ready = (state_q == IDLE) & ~rst;
   assign accept        = bus.req_valid & bus.req_ready;

   // With a single-cycle latency the access edge is the acceptance edge, so the
   // operands come straight off the bus instead of the capture registers.
   assign acc_we    = (state_q == IDLE) ? bus.req_we    : we_q;
   assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
   assign acc_be    = (state_q == IDLE) ? bus.req_be    : be_q;

   assign in_range  = {1'b0, acc_addr} < DEPTH_L;
   assign arr_en    = access & in_range & ~rst;

   // State and wait counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter is loaded with LATENCY-1 and RESP is entered on the edge where it
   // reaches zero, giving LATENCY-1 BUSY cycles before the response cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d = LOAD_VAL;
               if (LATENCY > 1) begin
                  state_d = BUSY;
               end else begin
                  state_d = RESP;
                  access  = 1'b1;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
               state_d = RESP;
               access  = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request capture; the datapath registers need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         be_q    <= bus.req_be;
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (acc_we),
      .addr  (acc_addr),
      .wdata (acc_wdata),
      .be    (acc_be),
      .rdata (arr_rdata)
   );

   // Response flags update only on the access edge so data and error hold until the next access.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         rd_sel_q     <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= access;
         if (access) begin
            rd_sel_q   <= ~acc_we & in_range;
            resp_err_q <= ~in_range;
         end
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = rd_sel_q ? arr_rdata : '0;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_waitstate.sv
// Self-checking bench: four differently configured instances driven with directed and
// randomized requests, checked against a word/byte-lane reference model.
module tb_dmem_waitstate;

   localparam int N_DUT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst        [N_DUT];
   logic        req_valid  [N_DUT];
   logic        req_we     [N_DUT];
   logic [7:0]  req_addr   [N_DUT];
   logic [31:0] req_wdata  [N_DUT];
   logic [3:0]  req_be     [N_DUT];
   logic        req_ready  [N_DUT];
   logic        resp_valid [N_DUT];
   logic [31:0] resp_rdata [N_DUT];
   logic        resp_err   [N_DUT];

   int compared   = 0;
   int mismatched = 0;

   // Reference memory: word contents plus a per-byte "has been written" flag.
   logic [31:0] mdata  [N_DUT][256];
   logic [3:0]  mknown [N_DUT][256];

   function automatic int lat_of(input int d);
      case (d)
         0:       return 2;
         1:       return 4;
         2:       return 1;
         default: return 15;
      endcase
   endfunction

   function automatic int depth_of(input int d);
      return (d == 0) ? 200 : 256;
   endfunction

   genvar g;
   generate
      for (g = 0; g < N_DUT; g++) begin : g_dut
         dmem_waitstate_if #(.DATA_W(32), .ADDR_W(8)) bus ();
         assign bus.req_valid = req_valid[g];
         assign bus.req_we    = req_we[g];
         assign bus.req_addr  = req_addr[g];
         assign bus.req_wdata = req_wdata[g];
         assign bus.req_be    = req_be[g];
         assign req_ready[g]  = bus.req_ready;
         assign resp_valid[g] = bus.resp_valid;
         assign resp_rdata[g] = bus.resp_rdata;
         assign resp_err[g]   = bus.resp_err;
         dmem_waitstate #(
            .DATA_W  (32),
            .ADDR_W  (8),
            .DEPTH   ((g == 0) ? 200 : 256),
            .LATENCY ((g == 0) ? 2 : ((g == 1) ? 4 : ((g == 2) ? 1 : 15)))
         ) dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
         );
      end
   endgenerate

   // Applies one request to the model; returns the expected data, error and compare mask.
   function automatic void model_access(input int d, input logic we, input logic [7:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be,
                                        output logic [31:0] er, output logic ee, output logic [31:0] em);
      er = '0;
      em = '1;
      ee = (int'(addr) >= depth_of(d));
      if (ee) return;
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mdata[d][addr][8*i +: 8] = wdata[8*i +: 8];
               mknown[d][addr][i] = 1'b1;
            end
         end
      end else begin
         er = mdata[d][addr];
         for (int i = 0; i < 4; i++) em[8*i +: 8] = {8{mknown[d][addr][i]}};
      end
   endfunction

   // Drives one request, waits for acceptance and the response, and reports the observed
   // latency in negedges after the acceptance edge together with the model expectation.
   task automatic run_txn(input int d, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic [31:0] er, output logic ee, output logic [31:0] em);
      int waited;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      waited = 0;
      while (!req_ready[d] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready[d]) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL accept_timeout dut%0d: req_ready=%0b required 1", d, req_ready[d]);
      end
      model_access(d, we, addr, wdata, be, er, ee, em);
      @(negedge clk);
      req_valid[d] = 1'b0;
      lat = 1;
      while (!resp_valid[d] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid[d]) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL resp_timeout dut%0d: resp_valid=%0b required 1", d, resp_valid[d]);
      end
      rd  = resp_rdata[d];
      err = resp_err[d];
   endtask

   task automatic test_reset();
      for (int d = 0; d < N_DUT; d++) begin
         rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
         req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int d = 0; d < N_DUT; d++) begin
            compared++;
            if (req_ready[d] !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL ready_in_reset dut%0d: got %0b required 0", d, req_ready[d]);
            end
         end
      end
      for (int d = 0; d < N_DUT; d++) rst[d] = 1'b0;
      #1;
      for (int d = 0; d < N_DUT; d++) begin
         compared++;
         if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL after_reset dut%0d: ready=%0b valid=%0b rdata=%h err=%0b required 1 0 00000000 0",
                     d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
         end
      end
   endtask

   task automatic test_round_trip();
      logic [31:0] rd, er, em;
      logic err, ee;
      int lat;
      run_txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, er, ee, em);
      compared++;
      if (lat !== 2 || err !== 1'b0 || rd !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL rt_write: lat=%0d err=%0b rdata=%h required 2 0 00000000", lat, err, rd);
      end
      run_txn(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, lat, er, ee, em);
      compared++;
      if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
         mismatched++;
         $display("[TB] FAIL rt_read: lat=%0d err=%0b rdata=%h required 2 0 deadbeef", lat, err, rd);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, er, em;
      logic err, ee;
      int lat;
      run_txn(0, 1'b1, 8'd5, 32'h11223344, 4'hF, rd, err, lat, er, ee, em);
      run_txn(0, 1'b1, 8'd5, 32'hAABBCCDD, 4'b0101, rd, err, lat, er, ee, em);
      run_txn(0, 1'b0, 8'd5, 32'h0, 4'h0, rd, err, lat, er, ee, em);
      compared++;
      if (rd !== 32'h11BB33DD || err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL byte_lanes: rdata=%h err=%0b required 11bb33dd 0", rd, err);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd, er, em;
      logic err, ee;
      int lat;
      run_txn(0, 1'b1, 8'd55, 32'h5555AAAA, 4'hF, rd, err, lat, er, ee, em);
      run_txn(0, 1'b0, 8'd200, 32'h0, 4'h0, rd, err, lat, er, ee, em);
      compared++;
      if (err !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
         mismatched++;
         $display("[TB] FAIL oor_read: err=%0b rdata=%h lat=%0d required 1 00000000 2", err, rd, lat);
      end
      run_txn(0, 1'b1, 8'd255, 32'h0BADF00D, 4'hF, rd, err, lat, er, ee, em);
      compared++;
      if (err !== 1'b1 || rd !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL oor_write: err=%0b rdata=%h required 1 00000000", err, rd);
      end
      run_txn(0, 1'b0, 8'd55, 32'h0, 4'h0, rd, err, lat, er, ee, em);
      compared++;
      if (rd !== 32'h5555AAAA || err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL no_alias: rdata=%h err=%0b required 5555aaaa 0", rd, err);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd, er, em;
      logic err, ee;
      int lat;
      bit seen;
      run_txn(1, 1'b1, 8'd7, 32'h0, 4'hF, rd, err, lat, er, ee, em);
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 8'd7;
      req_wdata[1] = 32'hCAFEF00D; req_be[1] = 4'hF;
      compared++;
      if (req_ready[1] !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rmw_accept: req_ready=%0b required 1", req_ready[1]);
      end
      @(negedge clk);
      req_valid[1] = 1'b0;
      rst[1] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         rst[1] = 1'b0;
         if (resp_valid[1]) seen = 1'b1;
      end
      compared++;
      if (seen !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rmw_no_resp: resp_valid seen=%0b required 0", seen);
      end
      run_txn(1, 1'b0, 8'd7, 32'h0, 4'h0, rd, err, lat, er, ee, em);
      compared++;
      if (rd !== 32'h0 || lat !== 4) begin
         mismatched++;
         $display("[TB] FAIL rmw_readback: rdata=%h lat=%0d required 00000000 4", rd, lat);
      end
   endtask

   task automatic test_random(input int d, input int n);
      logic [31:0] rd, er, em, wd;
      logic err, ee, we;
      logic [7:0] addr;
      logic [3:0] be;
      int lat;
      for (int t = 0; t < n; t++) begin
         we   = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         wd   = $urandom();
         be   = 4'($urandom_range(0, 15));
         run_txn(d, we, addr, wd, be, rd, err, lat, er, ee, em);
         compared++;
         if (lat !== lat_of(d) || err !== ee || (rd & em) !== (er & em)) begin
            mismatched++;
            $display("[TB] FAIL random dut%0d #%0d we=%0b addr=%0d: lat=%0d err=%0b rdata=%h required lat=%0d err=%0b rdata=%h mask=%h",
                     d, t, we, addr, lat, err, rd, lat_of(d), ee, er, em);
         end
      end
   endtask

   // Holds req_valid high continuously and checks acceptance spacing, response timing and data.
   task automatic test_latency_sweep(input int d, input int n_acc);
      int acc_cyc[$];
      int resp_cyc[$];
      logic [31:0] er, em;
      logic ee;
      bit pend, acc_now;
      int issued, cyc, budget, lat;
      lat    = lat_of(d);
      budget = n_acc * (lat + 1) + lat + 10;
      pend   = 1'b0;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = 1'($urandom_range(0, 1));
      req_addr[d]  = 8'($urandom_range(0, 7));
      req_wdata[d] = $urandom();
      req_be[d]    = 4'($urandom_range(0, 15));
      issued = 1;
      cyc    = 0;
      while (cyc < budget) begin
         if (resp_valid[d]) begin
            resp_cyc.push_back(cyc);
            compared++;
            if (!pend || resp_err[d] !== ee || (resp_rdata[d] & em) !== (er & em)) begin
               mismatched++;
               $display("[TB] FAIL sweep_data dut%0d cyc=%0d: pend=%0b err=%0b rdata=%h required err=%0b rdata=%h mask=%h",
                        d, cyc, pend, resp_err[d], resp_rdata[d], ee, er, em);
            end
            pend = 1'b0;
         end
         acc_now = req_valid[d] && req_ready[d];
         if (acc_now) begin
            acc_cyc.push_back(cyc);
            model_access(d, req_we[d], req_addr[d], req_wdata[d], req_be[d], er, ee, em);
            pend = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (acc_now) begin
            if (issued < n_acc) begin
               req_we[d]    = 1'($urandom_range(0, 1));
               req_addr[d]  = 8'($urandom_range(0, 7));
               req_wdata[d] = $urandom();
               req_be[d]    = 4'($urandom_range(0, 15));
               issued++;
            end else begin
               req_valid[d] = 1'b0;
            end
         end
      end
      compared++;
      if (acc_cyc.size() != n_acc || resp_cyc.size() != acc_cyc.size()) begin
         mismatched++;
         $display("[TB] FAIL sweep_count dut%0d: accepts=%0d responses=%0d required %0d each",
                  d, acc_cyc.size(), resp_cyc.size(), n_acc);
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         compared++;
         if (acc_cyc[i] - acc_cyc[i-1] != lat + 1) begin
            mismatched++;
            $display("[TB] FAIL sweep_spacing dut%0d #%0d: got %0d required %0d",
                     d, i, acc_cyc[i] - acc_cyc[i-1], lat + 1);
         end
      end
      for (int i = 0; i < acc_cyc.size() && i < resp_cyc.size(); i++) begin
         compared++;
         if (resp_cyc[i] - acc_cyc[i] != lat) begin
            mismatched++;
            $display("[TB] FAIL sweep_latency dut%0d #%0d: got %0d required %0d",
                     d, i, resp_cyc[i] - acc_cyc[i], lat);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < N_DUT; d++) begin
         for (int a = 0; a < 256; a++) begin
            mdata[d][a]  = '0;
            mknown[d][a] = '0;
         end
      end
      test_reset();
      test_round_trip();
      test_byte_lanes();
      test_out_of_range();
      test_reset_mid_write();
      test_random(0, 40);
      test_random(1, 15);
      test_latency_sweep(2, 12);
      test_latency_sweep(3, 6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
